bcd2bin_sequential_fsm: RTL and testbench



---
 rtl/bcd2bin_pkg.sv | 16 +
 rtl/bcd2bin_sequential_fsm_if.sv | 34 +++
 rtl/bcd_nibble_corr.sv | 18 +
 rtl/bcd2bin_sequential_fsm.sv | 153 +++++++++++++++
 tb/tb_bcd2bin_sequential_fsm.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   - state_e      : FSM states of the converter (idle, shifting, result cycle)
//   - DEFAULT_*    : default operand/result sizing (6 BCD digits -> 19-bit binary)
package bcd2bin_pkg;

    localparam int unsigned DEFAULT_DIGITS = 6;
    localparam int unsigned DEFAULT_BIN_W  = 19;
    localparam int unsigned DEFAULT_CNT_W  = $clog2(DEFAULT_BIN_W);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd2bin_sequential_fsm_if.sv
// Start/busy/done handshake bundle of the BCD-to-binary converter.
//   start : request a conversion (master -> slave)
//   bcd   : packed BCD operand, digit 0 in [3:0] (master -> slave)
//   bin   : binary result, held until the next completion (slave -> master)
//   busy  : conversion in progress (slave -> master)
//   done  : single-cycle completion pulse (slave -> master)
//   ovf   : operand does not fit in BIN_W bits (slave -> master)
//   err   : operand contained a non-decimal digit (slave -> master)
interface bcd2bin_sequential_fsm_if
    import bcd2bin_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS,
    parameter int unsigned BIN_W  = DEFAULT_BIN_W
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  err;

    modport master (
        output start, bcd,
        input  bin, busy, done, ovf, err
    );

    modport slave (
        input  start, bcd,
        output bin, busy, done, ovf, err
    );

endinterface

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble digit correction: after a right shift, a BCD nibble of
// 8 or more carried a '10' (worth 5 after halving) from the digit above, which
// shows up as 8; subtracting 3 turns it back into a valid 5.
//   nib_i : shifted BCD nibble
//   nib_o : corrected nibble
module bcd_nibble_corr (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i[3]) begin
            nib_o = nib_i - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin_sequential_fsm.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : start/bcd in, bin/busy/done/ovf/err out (slave modport)
// Build option: define BCD2BIN_DIGIT_CHECK_EN to flag operands containing a
// nibble > 9; such conversions complete with err=1 and bin=0. Without it err
// is tied low and invalid nibbles are converted arithmetically.
module bcd2bin_sequential_fsm
    import bcd2bin_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS,
    parameter int unsigned BIN_W  = DEFAULT_BIN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd2bin_sequential_fsm_if.slave   bus
);

    localparam int unsigned SR_W = 4 * DIGITS + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W);

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_corr;

    // One step: shift right, then fix every BCD digit in parallel.
    assign sr_shift = sr_q >> 1;
    assign sr_corr[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_corr u_corr (
            .nib_i (sr_shift[BIN_W + 4*g +: 4]),
            .nib_o (sr_corr[BIN_W + 4*g +: 4])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic err_pend_q, err_pend_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d      = err_q;
        err_pend_d = err_pend_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (bus.start) begin
                    state_d = StShift;
                    sr_d    = {bus.bcd, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_pend_d = bad_digit;
`endif
                end
            end

            StShift: begin
                sr_d  = sr_corr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    // Final shift: results are captured from this step's value.
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bin_d   = sr_corr[BIN_W-1:0];
                    ovf_d   = |sr_corr[SR_W-1:BIN_W];
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_d = err_pend_q;
                    if (err_pend_q) begin
                        bin_d = '0;
                        ovf_d = 1'b0;
                    end
`endif
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
`endif
        end
    end

    assign bus.bin  = bin_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_sequential_fsm.sv
// Self-checking bench for bcd2bin_sequential_fsm: table of operands with
// hand-computed results, plus back-to-back, ignored-start, mid-run reset and
// invalid-digit sequences. Cycle 0 is the cycle in which start is presented;
// done is expected in cycle 20 and busy in cycles 1..19.
module tb_bcd2bin_sequential_fsm;
    import bcd2bin_pkg::*;

    localparam int unsigned DIGITS = DEFAULT_DIGITS;
    localparam int unsigned BIN_W  = DEFAULT_BIN_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd2bin_sequential_fsm_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin_sequential_fsm #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] bcd;
        logic [18:0] bin;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [23:0] v);
        bus.bcd   = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle number at which done is seen.
    task automatic wait_done(output int lat, output int busy_n, output bit seen);
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    int  lat;
    int  busy_n;
    bit  seen;
    int  done_cnt;

    initial begin
        vecs[0] = '{bcd: 24'h123456, bin: 19'h1E240, ovf: 1'b0};
        vecs[1] = '{bcd: 24'h524287, bin: 19'h7FFFF, ovf: 1'b0};
        vecs[2] = '{bcd: 24'h524288, bin: 19'h00000, ovf: 1'b1};
        vecs[3] = '{bcd: 24'h999999, bin: 19'h7423F, ovf: 1'b1};
        vecs[4] = '{bcd: 24'h000000, bin: 19'h00000, ovf: 1'b0};
        vecs[5] = '{bcd: 24'h000042, bin: 19'h0002A, ovf: 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_bin",  bus.bin,  0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_ovf",  bus.ovf,  0);
        check("reset_err",  bus.err,  0);
        tick();

        // Table-driven conversions.
        for (int i = 0; i < 6; i++) begin
            start_conv(vecs[i].bcd);
            wait_done(lat, busy_n, seen);
            check($sformatf("vec%0d_done_seen", i), seen, 1);
            check($sformatf("vec%0d_latency", i), lat, 20);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, 19);
            check($sformatf("vec%0d_bin", i), bus.bin, vecs[i].bin);
            check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
            check($sformatf("vec%0d_err", i), bus.err, 0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
            check($sformatf("vec%0d_bin_hold", i), bus.bin, vecs[i].bin);
            tick();
        end

        // Back-to-back: restart in the done cycle.
        start_conv(24'h000000);
        wait_done(lat, busy_n, seen);
        check("b2b_first_seen", seen, 1);
        check("b2b_first_bin", bus.bin, 0);
        start_conv(24'h000001);
        wait_done(lat, busy_n, seen);
        check("b2b_second_seen", seen, 1);
        check("b2b_second_latency", lat, 20);
        check("b2b_second_bin", bus.bin, 1);
        tick();
        tick();

        // Start pulses during SHIFT are ignored.
        start_conv(24'h000123);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5 || c == 10) begin
                bus.start = 1'b1;
                bus.bcd   = 24'h999999;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            tick();
        end
        bus.start = 1'b0;
        check("ignore_seen", seen, 1);
        check("ignore_latency", lat, 20);
        check("ignore_bin", bus.bin, 19'h0007B);
        check("ignore_ovf", bus.ovf, 0);
        tick();
        check("ignore_no_requeue_busy", bus.busy, 0);
        check("ignore_no_requeue_done", bus.done, 0);
        tick();

        // Reset in shift cycle 8 aborts the conversion.
        start_conv(24'h123456);
        for (int c = 1; c < 8; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_bin",   bus.bin,  0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_ovf",   bus.ovf,  0);
        check("rst_err",   bus.err,  0);
        check("rst_state", u_dut.state_q, StIdle);
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check("rst_no_done", done_cnt, 0);
        start_conv(24'h000042);
        wait_done(lat, busy_n, seen);
        check("post_rst_seen", seen, 1);
        check("post_rst_bin", bus.bin, 42);
        tick();

        // Non-decimal digit.
        start_conv(24'h00001A);
        wait_done(lat, busy_n, seen);
        check("bad_digit_seen", seen, 1);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        check("bad_digit_err", bus.err, 1);
        check("bad_digit_bin", bus.bin, 0);
        check("bad_digit_ovf", bus.ovf, 0);
`else
        check("bad_digit_err", bus.err, 0);
`endif
        tick();
        start_conv(24'h000042);
        wait_done(lat, busy_n, seen);
        check("after_bad_seen", seen, 1);
        check("after_bad_err", bus.err, 0);
        check("after_bad_bin", bus.bin, 42);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
